// File: rtl/pio_instr_receiver.sv
// rtl/pio_instr_receiver.sv - HPS instruction PIO receiver: wrreg strobe capture into a FWFT FIFO
//
// Captures {data_a_in, data_b_in} once per rising edge of the wrreg_in level
// strobe and queues the pair in a first-word-fall-through FIFO drained by the
// graphics pipeline with instr_rd_en.
//
// Optional build macro: PIO_RX_SYNC_EN
//   defined   - wrreg_in and both data words pass through two register stages
//               before the strobe FSM (push lands 2 cycles after the rise).
//   undefined - wrreg_in feeds the FSM directly (push in the first high cycle).
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   data_a_in/_b_in     PIO out_port values captured on a push
//   wrreg_in            level strobe from software
//   instr_rd_en         consumer pop request (ignored while empty)
//   instr_valid         head entry present
//   instr_data_a/_b     head entry (0 while empty)
//   fifo_full/_empty    occupancy status
//   fifo_count          entries held, 0..DEPTH
//   overflow            sticky: a strobe was dropped while full
//   overflow_clr        clears overflow (a same-cycle drop wins)

module pio_instr_receiver #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_a_in,
    input  logic [DATA_W-1:0] data_b_in,
    input  logic              wrreg_in,
    input  logic              instr_rd_en,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data_a,
    output logic [DATA_W-1:0] instr_data_b,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t state, state_next;

    logic              strobe;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;

`ifdef PIO_RX_SYNC_EN
    logic              sync1, sync2;
    logic [DATA_W-1:0] a_d1, a_d2, b_d1, b_d2;

    // Data follows the same two stages as the strobe so the word captured on
    // the push is the one present when wrreg_in was first seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            a_d1  <= '0;
            a_d2  <= '0;
            b_d1  <= '0;
            b_d2  <= '0;
        end else begin
            sync1 <= wrreg_in;
            sync2 <= sync1;
            a_d1  <= data_a_in;
            a_d2  <= a_d1;
            b_d1  <= data_b_in;
            b_d2  <= b_d1;
        end
    end

    assign strobe = sync2;
    assign cap_a  = a_d2;
    assign cap_b  = b_d2;
`else
    assign strobe = wrreg_in;
    assign cap_a  = data_a_in;
    assign cap_b  = data_b_in;
`endif

    // Strobe edge detector: one push request per low-to-high of the strobe.
    logic push_req;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        case (state)
            S_IDLE: begin
                if (strobe) begin
                    push_req   = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!strobe) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FIFO storage and pointers
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;

    logic is_full, is_empty, pop, push, drop;

    assign is_full  = (count == DEPTH_CNT);
    assign is_empty = (count == '0);
    assign pop      = instr_rd_en && !is_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req && (!is_full || pop);
    assign drop     = push_req && is_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= cap_a;
            mem_b[wr_ptr] <= cap_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    assign fifo_count   = count;
    assign fifo_full    = is_full;
    assign fifo_empty   = is_empty;
    assign instr_valid  = !is_empty;
    assign instr_data_a = is_empty ? '0 : mem_a[rd_ptr];
    assign instr_data_b = is_empty ? '0 : mem_b[rd_ptr];

endmodule

// File: tb/tb_pio_instr_receiver.sv
// tb/tb_pio_instr_receiver.sv - directed scoreboard bench for pio_instr_receiver

module tb_pio_instr_receiver;

`ifdef PIO_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_a, data_b;
    logic        wrreg, rd_en, ovf_clr;
    logic        instr_valid, fifo_full, fifo_empty, overflow;
    logic [31:0] instr_data_a, instr_data_b;
    logic [4:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] head;

    always #5 clk = ~clk;

    pio_instr_receiver #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_a_in    (data_a),
        .data_b_in    (data_b),
        .wrreg_in     (wrreg),
        .instr_rd_en  (rd_en),
        .instr_valid  (instr_valid),
        .instr_data_a (instr_data_a),
        .instr_data_b (instr_data_b),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (ovf_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the head against the scoreboard, then pop it.
    task automatic pop_one(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed pop expected empty scoreboard", tag);
        end else begin
            head = exp_q.pop_front();
            check({tag, "_valid"}, 64'(instr_valid), 64'd1);
            check({tag, "_data"}, {instr_data_a, instr_data_b}, head);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // Full strobe: rise, hold, fall; scoreboard decides accept or drop.
    task automatic do_strobe(input logic [31:0] a, input logic [31:0] b);
        data_a = a;
        data_b = b;
        wrreg  = 1'b1;
        repeat (1 + LAT) tick();
        if (exp_q.size() < 16) exp_q.push_back({a, b});
        repeat (2) tick();
        wrreg = 1'b0;
        repeat (1 + LAT) tick();
    endtask

    initial begin
        reset = 1'b1; data_a = '0; data_b = '0;
        wrreg = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_full",  64'(fifo_full),  64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_ovf",   64'(overflow),   64'd0);
        check("rst_data",  {instr_data_a, instr_data_b}, 64'd0);

        // Single strobe held 5 cycles -> exactly one entry
        data_a = 32'h0000_1234;
        data_b = 32'hDEAD_BEEF;
        wrreg  = 1'b1;
        repeat (1 + LAT) tick();
        exp_q.push_back({32'h0000_1234, 32'hDEAD_BEEF});
        check("single_valid", 64'(instr_valid), 64'd1);
        check("single_count", 64'(fifo_count), 64'd1);
        repeat (4) tick();
        wrreg = 1'b0;
        repeat (1 + LAT) tick();
        check("single_hold_count", 64'(fifo_count), 64'd1);
        pop_one("single_pop");
        check("single_empty", 64'(fifo_empty), 64'd1);

        // Burst fill, overflow on the 17th, drain in order
        for (int i = 0; i < 16; i++) do_strobe(32'(i), 32'(i) ^ 32'h5A5A_0000);
        check("fill_full",  64'(fifo_full),  64'd1);
        check("fill_count", 64'(fifo_count), 64'd16);
        check("fill_ovf0",  64'(overflow),   64'd0);
        do_strobe(32'd16, 32'hFFFF_FFFF);
        check("ovf_set",   64'(overflow),   64'd1);
        check("ovf_count", 64'(fifo_count), 64'd16);
        for (int i = 0; i < 16; i++) pop_one("drain");
        check("drain_empty", 64'(fifo_empty), 64'd1);
        check("drain_data0", {instr_data_a, instr_data_b}, 64'd0);

        // Clear, refill, then a clear racing a dropped push
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) do_strobe(32'h100 + 32'(i), 32'(i));
        data_a = 32'hBAD; data_b = 32'hBAD;
        wrreg  = 1'b1;
        repeat (LAT) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("race_ovf",   64'(overflow),   64'd1);
        check("race_count", 64'(fifo_count), 64'd16);
        wrreg = 1'b0;
        repeat (1 + LAT) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("race_clr", 64'(overflow), 64'd0);

        // Full: pop and push in the same cycle
        data_a = 32'hAA; data_b = 32'h55;
        wrreg  = 1'b1;
        repeat (LAT) tick();
        head = exp_q.pop_front();
        check("fullpp_head", {instr_data_a, instr_data_b}, head);
        exp_q.push_back({32'hAA, 32'h55});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fullpp_count", 64'(fifo_count), 64'd16);
        check("fullpp_ovf",   64'(overflow),   64'd0);
        wrreg = 1'b0;
        repeat (1 + LAT) tick();
        for (int i = 0; i < 16; i++) pop_one("fullpp_drain");
        check("fullpp_empty", 64'(fifo_empty), 64'd1);

        // Not full: pop and push in the same cycle keep the count
        do_strobe(32'h77, 32'h88);
        data_a = 32'h99; data_b = 32'h11;
        wrreg  = 1'b1;
        repeat (LAT) tick();
        head = exp_q.pop_front();
        check("pp_head", {instr_data_a, instr_data_b}, head);
        exp_q.push_back({32'h99, 32'h11});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("pp_count", 64'(fifo_count), 64'd1);
        wrreg = 1'b0;
        repeat (1 + LAT) tick();
        pop_one("pp_pop");

        // Underflow is ignored
        rd_en = 1'b1;
        repeat (2) tick();
        rd_en = 1'b0;
        check("underflow_count", 64'(fifo_count), 64'd0);
        check("underflow_empty", 64'(fifo_empty), 64'd1);

        // Reset mid-operation with wrreg held high
        for (int i = 0; i < 3; i++) do_strobe(32'h200 + 32'(i), 32'h0);
        check("load3_count", 64'(fifo_count), 64'd3);
        data_a = 32'hC0FFEE; data_b = 32'h1;
        wrreg  = 1'b1;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        exp_q.delete();
        check("midrst_count", 64'(fifo_count), 64'd0);
        check("midrst_empty", 64'(fifo_empty), 64'd1);
        repeat (1 + LAT) tick();
        exp_q.push_back({32'hC0FFEE, 32'h1});
        check("postrst_count", 64'(fifo_count), 64'd1);
        repeat (4) tick();
        check("postrst_once", 64'(fifo_count), 64'd1);
        wrreg = 1'b0;
        repeat (1 + LAT) tick();
        pop_one("postrst_pop");
        check("final_empty", 64'(fifo_empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_instr_receiver.md
Name: pio_instr_receiver

Overview:
FPGA-side consumer of the HPS instruction PIOs: data_A, data_B and the wrreg strobe.
- Watches the wrreg strobe driven by the HPS through a PIO out_port.
- On each strobe assertion, captures the 64-bit instruction pair {data_A, data_B}.
- Queues each pair in a first-word-fall-through FIFO for the graphics pipeline, which drains it with a pop handshake.
- Reports FIFO status and a sticky overflow flag, so the status path back to the HPS can throttle software.

Parameters:
DATA_W, 32, width of each of data_a_in / data_b_in.
DEPTH, 16, FIFO entries; must be a power of two, >= 2.
ADDR_W, 4, log2(DEPTH); FIFO pointer width.

Ports:
clk  in  1  system clock; same clock as the PIO slaves.
reset  in  1  synchronous, active-high reset.
data_a_in  in  DATA_W  data_A PIO out_port value.
data_b_in  in  DATA_W  data_B PIO out_port value.
wrreg_in  in  1  wrreg PIO bit 0; level strobe from software.
instr_rd_en  in  1  consumer pop request.
instr_valid  out  1  head entry present (equals ~fifo_empty).
instr_data_a  out  DATA_W  head entry, data_A half.
instr_data_b  out  DATA_W  head entry, data_B half.
fifo_full  out  1  count == DEPTH.
fifo_empty  out  1  count == 0.
fifo_count  out  ADDR_W+1  entries held, 0..DEPTH.
overflow  out  1  sticky: a strobe was dropped because the FIFO was full.
overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (synchronous, active-high; takes effect at the clk edge where reset=1):
  - pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0, instr_valid=0, overflow=0.
  - instr_data_a/b read 0 while empty.
  - FSM goes to S_IDLE. Reset mid-strobe discards any pending capture.
- Strobe FSM (2 states):
  - S_IDLE: wrreg_in=1 -> issue one push request this cycle, go to S_HOLD. Otherwise stay.
  - S_HOLD: wrreg_in=0 -> go to S_IDLE. Otherwise stay; no further pushes.
  - Exactly one push per 0->1 transition of wrreg_in, regardless of how long it stays high.
  - wrreg_in high out of reset: push on the first post-reset cycle.
- Capture: the push writes {data_a_in, data_b_in} as sampled in the push cycle. Software must hold data stable before raising wrreg.
- Latency: push at edge N -> instr_valid=1 and head data visible after edge N (combinationally from RAM/regs, first-word fall-through).
- Pop: effective when instr_rd_en & ~fifo_empty. The head advances at the next edge. instr_rd_en while empty is ignored; no underflow.
- Simultaneous push & pop:
  - not full: count unchanged, both pointers advance.
  - full: the pop frees a slot and the push is accepted; count stays DEPTH, no overflow.
  - empty: the pop is ignored, the push is accepted, count becomes 1.
- Overflow: push while full with no effective pop -> data dropped, overflow set next cycle, count unchanged.
  - overflow_clr=1 clears it.
  - Set has priority over a same-cycle clear.
- Pointers wrap modulo DEPTH. fifo_count is a true occupancy count; full is distinguished from empty by the count, not by pointer equality.
- All outputs are registered or derived from registered state; there is no combinational path from wrreg_in to status outputs.

Optional Feature:
Macro PIO_RX_SYNC_EN.
- Defined:
  - wrreg_in passes through a 2-flop synchronizer before the FSM, for PIOs driven from another clock domain.
  - Push occurs 2 cycles after wrreg_in rises.
  - data_a_in/data_b_in are also registered twice, aligned with the synchronized strobe.
  - Reset clears the synchronizer flops to 0.
- Undefined: wrreg_in feeds the FSM directly; push in the same cycle wrreg_in is first seen high.

Test Plan:
- Single strobe: data_a=0x0000_1234, data_b=0xDEAD_BEEF, wrreg 0->1 held 5 cycles -> exactly one entry, fifo_count=1, instr_data_a=0x1234, instr_data_b=0xDEADBEEF, instr_valid=1 next cycle.
- Burst fill: 16 strobes with data_a=i (i=0..15) -> fifo_full=1, count=16. A 17th strobe -> overflow=1, count stays 16. Draining pops return 0..15 in order, then fifo_empty=1.
- Full plus simultaneous pop and push: with the FIFO full, pulse instr_rd_en in the same cycle as a new strobe with data_a=0xAA -> count=16, overflow stays 0, last entry read = 0xAA.
- Overflow clear race: overflow_clr=1 in the same cycle as a dropped push -> overflow remains 1. overflow_clr alone the next cycle -> overflow=0.
- Underflow and reset mid-operation: instr_rd_en=1 while empty -> count stays 0. Load 3 entries, assert reset for 1 cycle while wrreg_in=1 -> count=0, empty=1; after reset releases with wrreg still high, exactly one push.
- With PIO_RX_SYNC_EN: a wrreg rise at cycle 10 -> instr_valid first high after edge 12, carrying the data present at cycle 10.
